// File: rtl/adc_stream_receiver.sv
// adc_stream_receiver: AXI-Stream slave that terminates the ADC sample stream.
// It aligns capture to packet boundaries and buffers captured words in a FIFO.
// It checks each packet's length against expected_len and keeps statistics counters.
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   s_axis_*             stream slave (tdata/tvalid/tlast in, tready out)
//   enable               capture enable (level)
//   expected_len         expected words per packet, 0 disables the check
//   rd_en/rd_data/rd_valid  FIFO read side, data one cycle after the request
//   fifo_count/empty/full   registered FIFO occupancy
//   words_received, packets_received, last_pkt_len, len_errors, discarded_words
module adc_stream_receiver #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   input  logic                  enable,
   input  logic [15:0]           expected_len,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic [31:0]           words_received,
   output logic [15:0]           packets_received,
   output logic [15:0]           last_pkt_len,
   output logic [15:0]           len_errors,
   output logic [31:0]           discarded_words
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SYNC, RECV} state_t;

   state_t                  state_q, state_d;
   logic                    mid_pkt_q;
   logic                    mid_pkt_d;
   logic                    beat_c;
   logic                    wr_en_c;
   logic                    discard_c;
   logic                    rd_fire_c;
   logic [CW-1:0]           count_d;
   logic [15:0]             pkt_words_q;
   logic [15:0]             pkt_len_c;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // Outside RECV the source is never stalled; inside, only a full FIFO stalls it.
   assign s_axis_tready = (state_q == RECV) ? ~fifo_full : 1'b1;
   assign beat_c        = s_axis_tvalid & s_axis_tready;
   // Packet boundary tracking after this cycle's beat is applied.
   assign mid_pkt_d     = beat_c ? ~s_axis_tlast : mid_pkt_q;
   assign rd_fire_c     = rd_en & ~fifo_empty;
   assign count_d       = fifo_count + CW'(wr_en_c) - CW'(rd_fire_c);
   assign pkt_len_c     = (pkt_words_q == 16'hFFFF) ? 16'hFFFF : 16'(pkt_words_q + 16'd1);

   // Capture state register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= IDLE;
         mid_pkt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mid_pkt_q <= mid_pkt_d;
      end
   end

   // Next state and per-beat routing (store vs discard).
   always_comb begin
      state_d   = state_q;
      wr_en_c   = 1'b0;
      discard_c = 1'b0;
      case (state_q)
         IDLE: begin
            discard_c = beat_c;
            if (enable) state_d = mid_pkt_d ? SYNC : RECV;
         end
         SYNC: begin
            discard_c = beat_c;
            if (!enable)                     state_d = IDLE;
            else if (beat_c && s_axis_tlast) state_d = RECV;
         end
         RECV: begin
            wr_en_c = beat_c;
            // Leave only on a packet boundary so packets are never truncated.
            if (!enable && !mid_pkt_d) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO storage; flushed through the pointers, so no reset needed.
   always_ff @(posedge aclk) begin
      if (wr_en_c) mem[wr_ptr_q] <= s_axis_tdata;
   end

   // FIFO pointers, occupancy flags and read port.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_count <= '0;
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else begin
         if (wr_en_c)   wr_ptr_q <= ADDR_WIDTH'(wr_ptr_q + 1'b1);
         if (rd_fire_c) begin
            rd_ptr_q <= ADDR_WIDTH'(rd_ptr_q + 1'b1);
            rd_data  <= mem[rd_ptr_q];
         end
         rd_valid   <= rd_fire_c;
         fifo_count <= count_d;
         fifo_empty <= (count_d == '0);
         fifo_full  <= (count_d == CW'(DEPTH));
      end
   end

   // Statistics and packet length check.
   always_ff @(posedge aclk) begin
      if (areset) begin
         pkt_words_q      <= '0;
         words_received   <= '0;
         packets_received <= '0;
         last_pkt_len     <= '0;
         len_errors       <= '0;
         discarded_words  <= '0;
      end else begin
         if (discard_c) discarded_words <= discarded_words + 32'd1;
         if (wr_en_c) begin
            words_received <= words_received + 32'd1;
            if (s_axis_tlast) begin
               pkt_words_q      <= '0;
               last_pkt_len     <= pkt_len_c;
               packets_received <= packets_received + 16'd1;
               if (expected_len != 16'd0 && pkt_len_c != expected_len &&
                   len_errors != 16'hFFFF)
                  len_errors <= len_errors + 16'd1;
            end else begin
               pkt_words_q <= pkt_len_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_stream_receiver.sv
// Testbench for adc_stream_receiver: random stream traffic against a queue-based
// reference model; read data is checked by a scoreboard monitor.
module tb_adc_stream_receiver;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

   logic           clk = 1'b0;
   logic           areset;
   logic [DW-1:0]  s_axis_tdata;
   logic           s_axis_tvalid;
   logic           s_axis_tlast;
   logic           s_axis_tready;
   logic           enable;
   logic [15:0]    expected_len;
   logic           rd_en;
   logic [DW-1:0]  rd_data;
   logic           rd_valid;
   logic [AW:0]    fifo_count;
   logic           fifo_empty;
   logic           fifo_full;
   logic [31:0]    words_received;
   logic [15:0]    packets_received;
   logic [15:0]    last_pkt_len;
   logic [15:0]    len_errors;
   logic [31:0]    discarded_words;

   adc_stream_receiver #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .aclk(clk), .areset(areset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .enable(enable), .expected_len(expected_len),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .words_received(words_received), .packets_received(packets_received),
      .last_pkt_len(last_pkt_len), .len_errors(len_errors),
      .discarded_words(discarded_words)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: capture mode, upstream boundary, stored words and statistics.
   typedef enum int {M_OFF, M_ALIGN, M_CAPTURE} mode_t;
   mode_t           mode = M_OFF;
   bit              in_pkt = 1'b0;
   logic [DW-1:0]   mq[$];
   logic [DW-1:0]   sb_q[$];
   int unsigned     cur_len = 0;
   int unsigned     m_words = 0;
   int unsigned     m_disc = 0;
   logic [15:0]     m_pkts = '0;
   logic [15:0]     m_last = '0;
   logic [15:0]     m_err = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every read strobe must match the oldest expected word.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got data %0h expected no read", rd_data);
         end else begin
            chk("rd_data", rd_data, sb_q.pop_front());
         end
      end
   end

   // One clock: compare outputs with the model, advance the model, take the edge.
   task automatic step(output bit beat_o);
      bit rdy, beat, rd, mid_after;
      int unsigned len;
      rdy = (mode == M_CAPTURE) ? (mq.size() < DEPTH) : 1'b1;
      chk("tready", 32'(s_axis_tready), 32'(rdy));
      chk("fifo_count", 32'(fifo_count), mq.size());
      chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
      chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      chk("words_received", words_received, m_words);
      chk("packets_received", 32'(packets_received), 32'(m_pkts));
      chk("last_pkt_len", 32'(last_pkt_len), 32'(m_last));
      chk("len_errors", 32'(len_errors), 32'(m_err));
      chk("discarded_words", discarded_words, m_disc);
      beat = s_axis_tvalid && rdy;
      rd   = rd_en && (mq.size() > 0);
      if (areset) begin
         mode = M_OFF; in_pkt = 1'b0; mq.delete(); cur_len = 0;
         m_words = 0; m_disc = 0; m_pkts = '0; m_last = '0; m_err = '0;
         rd = 1'b0;
         beat = 1'b0;
      end else begin
         if (rd) sb_q.push_back(mq.pop_front());
         mid_after = beat ? !s_axis_tlast : in_pkt;
         if (beat && mode == M_CAPTURE) begin
            mq.push_back(s_axis_tdata);
            m_words++;
            cur_len++;
            if (s_axis_tlast) begin
               len = (cur_len > 16'hFFFF) ? 16'hFFFF : cur_len;
               m_last = 16'(len);
               m_pkts++;
               if (expected_len != 0 && len != expected_len && m_err != 16'hFFFF) m_err++;
               cur_len = 0;
            end
         end else if (beat) begin
            m_disc++;
         end
         case (mode)
            M_OFF:     if (enable) mode = mid_after ? M_ALIGN : M_CAPTURE;
            M_ALIGN:   if (!enable) mode = M_OFF;
                       else if (beat && s_axis_tlast) mode = M_CAPTURE;
            M_CAPTURE: if (!enable && !mid_after) mode = M_OFF;
            default:   mode = M_OFF;
         endcase
         in_pkt = mid_after;
      end
      beat_o = beat;
      @(posedge clk);
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(rd));
   endtask

   // Drive words [first, stop) of a len-word packet; enable drops once word drop_at is reached.
   task automatic send_words(input int first, input int stop, input int len,
                             input int drop_at, input int rd_pct);
      int idx = first, guard = 0, stall = 0;
      bit b;
      while (idx < stop) begin
         s_axis_tvalid = ($urandom_range(99) < 80);
         s_axis_tdata  = $urandom;
         s_axis_tlast  = s_axis_tvalid ? (idx == len - 1) : 1'($urandom_range(1));
         if (drop_at >= 0 && idx >= drop_at) enable = 1'b0;
         rd_en = ($urandom_range(99) < rd_pct) || (stall >= 6);
         step(b);
         if (b) begin
            idx++;
            stall = 0;
         end else if (s_axis_tvalid) begin
            stall++;
         end
         guard++;
         if (guard > 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got %0d words expected %0d", idx, stop);
            break;
         end
      end
      s_axis_tvalid = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic idle(input int n, input int rd_pct);
      bit b;
      for (int i = 0; i < n; i++) begin
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = $urandom;
         s_axis_tlast  = 1'($urandom_range(1));
         rd_en = ($urandom_range(99) < rd_pct);
         step(b);
      end
      rd_en = 1'b0;
   endtask

   task automatic drain();
      bit b;
      int guard = 0;
      s_axis_tvalid = 1'b0;
      while (mq.size() > 0 && guard < 200) begin
         rd_en = 1'b1;
         step(b);
         guard++;
      end
      rd_en = 1'b0;
      idle(2, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit b;
      int len, el;
      areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
      enable = 1'b0; expected_len = 16'd0; rd_en = 1'b0;
      @(posedge clk); #1;
      step(b);
      areset = 1'b0;

      // Three 5-word packets captured with no reads, then read back in order.
      enable = 1'b1; expected_len = 16'd5;
      idle(3, 0);
      for (int p = 0; p < 3; p++) send_words(0, 5, 5, -1, 0);
      idle(2, 0);
      drain();

      // Enable raised mid-packet: rest of that packet discarded, next one captured.
      enable = 1'b0;
      idle(2, 0);
      send_words(0, 5, 16, -1, 0);
      enable = 1'b1;
      send_words(5, 16, 16, -1, 0);
      send_words(0, 8, 8, -1, 20);
      drain();

      // Overfill: 20-word packet into a 16-deep FIFO, reads only when stalled.
      expected_len = 16'd0;
      send_words(0, 20, 20, -1, 0);
      drain();

      // Length checks: 8, 7 and 9 words against expected 8.
      expected_len = 16'd8;
      send_words(0, 8, 8, -1, 30);
      send_words(0, 7, 7, -1, 30);
      send_words(0, 9, 9, -1, 30);
      drain();

      // Enable dropped at word 3: packet completes, following packet discarded.
      send_words(0, 16, 16, 3, 0);
      drain();
      send_words(0, 16, 16, -1, 0);
      idle(2, 0);

      // Reset with 10 words buffered, then a read on the empty FIFO.
      enable = 1'b1;
      expected_len = 16'd16;
      idle(1, 0);
      send_words(0, 10, 16, -1, 0);
      areset = 1'b1;
      rd_en = 1'b1;
      step(b);
      areset = 1'b0;
      step(b);
      rd_en = 1'b0;
      send_words(10, 16, 16, -1, 0);
      drain();

      // Random soak: lengths, enable toggling, expected lengths, read rates.
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(20, 1);
         case ($urandom_range(2))
            0:       el = 0;
            1:       el = len;
            default: el = $urandom_range(20, 1);
         endcase
         expected_len = 16'(el);
         if ($urandom_range(3) == 0) enable = ~enable;
         send_words(0, len, len, ($urandom_range(4) == 0) ? int'($urandom_range(len - 1)) : -1,
                    $urandom_range(70, 10));
         if ($urandom_range(3) == 0) idle($urandom_range(4, 1), 50);
      end
      enable = 1'b0;
      drain();
      idle(3, 0);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_stream_receiver.md
Name: adc_stream_receiver

Overview:
- AXI-Stream slave that terminates the 32-bit ADC sample stream (tdata/tvalid/tlast) produced by the ADC block.
- Aligns capture to packet boundaries, buffers accepted words in an internal FIFO and applies backpressure through tready.
- Checks packet length against a programmable expectation and exposes FIFO read and statistics counters to the PS register map.
- Sits between the ADC stream output and the CPU/DMA read side.

Parameters:
DATA_WIDTH, 32, stream word width
ADDR_WIDTH, 10, FIFO depth = 2^ADDR_WIDTH words

Ports:
aclk  in  1  system clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tlast  in  1  last word of packet
s_axis_tready  out  1  stream ready
enable  in  1  capture enable (level)
expected_len  in  16  expected words per packet; 0 disables check
rd_en  in  1  FIFO read request
rd_data  out  DATA_WIDTH  FIFO read data
rd_valid  out  1  rd_data valid strobe
fifo_count  out  ADDR_WIDTH+1  words stored
fifo_empty  out  1  fifo_count == 0
fifo_full  out  1  fifo_count == 2^ADDR_WIDTH
words_received  out  32  words written to FIFO, wrapping
packets_received  out  16  completed packets written, wrapping
last_pkt_len  out  16  length of last completed packet
len_errors  out  16  length mismatches, saturating at 0xFFFF
discarded_words  out  32  beats accepted but not stored, wrapping

Behaviour:
- Beat = cycle with s_axis_tvalid & s_axis_tready.
- On areset:
  - All outputs and counters are 0; fifo_empty=1.
  - FIFO is flushed, state=IDLE, mid_pkt flag=0.
  - Reset mid-packet needs no extra handling; it follows from the above.
- mid_pkt flag:
  - Set on any beat with tlast=0.
  - Cleared on any beat with tlast=1.
  - Tracks the upstream boundary in every state.
- s_axis_tready:
  - 1 in IDLE and SYNC, so words are discarded and never stall the source.
  - In RECV, equals !fifo_full. Combinational from registered fifo_full only; it never depends on s_axis_tvalid.
- State machine:
  - IDLE:
    - Beats discarded; discarded_words++ per beat.
    - If enable=1 and mid_pkt=0 (after this cycle's beat is applied), go to RECV.
    - If enable=1 and mid_pkt=1, go to SYNC.
  - SYNC:
    - Beats discarded and counted.
    - Go to RECV the cycle after a beat with tlast=1.
    - If enable drops, go to IDLE.
  - RECV:
    - Each beat writes tdata to the FIFO and increments pkt_words (16-bit, saturating at 0xFFFF) and words_received.
    - On a beat with tlast=1:
      - last_pkt_len <= pkt_words+1 (saturating).
      - packets_received++.
      - If expected_len != 0 and the length != expected_len, len_errors++.
      - pkt_words <= 0.
    - If enable=0 at a boundary (mid_pkt=0, no beat in progress), go to IDLE.
    - If enable drops mid-packet, finish the current packet in RECV, then go to IDLE after its tlast beat. Packets are never truncated in the FIFO.
- FIFO:
  - Write and read pointers are ADDR_WIDTH bits and wrap modulo depth.
  - Read with rd_en=1 and fifo_empty=0: rd_data valid and rd_valid=1 on the next cycle.
    - rd_valid is a 1-cycle pulse.
    - rd_data holds its value until the next read.
  - rd_en while empty is ignored (rd_valid=0, no pointer change).
  - Read and write in the same cycle: both occur and fifo_count is unchanged.
    - When empty, the read is ignored and the write proceeds, so count=1 next cycle. No write-through bypass.
    - When full, tready=0 so the write cannot occur; the read proceeds and count decrements.
  - fifo_count, fifo_empty and fifo_full are registered and consistent in the same cycle.
- Counter rules:
  - words_received, discarded_words and packets_received wrap.
  - len_errors saturates at 0xFFFF.
  - A beat with tvalid=0 never changes any counter.

Test Plan:
- Reset then enable=1 with idle stream; send 3 packets of 16 words (tdata=0..47, tlast every 16th); expected_len=16 -> packets_received=3, words_received=48, len_errors=0, last_pkt_len=16, fifo_count=48, reads return 0..47 in order with 1-cycle rd_valid latency.
- enable raised while the source is at word 5 of a 16-word packet -> SYNC; 11 words discarded (discarded_words=11); capture starts at the next packet; first read returns that packet's word 0.
- ADDR_WIDTH=4, no reads, 20-word packet -> tready drops after 16 writes, fifo_full=1; one rd_en -> count=15, tready=1, remaining words accepted in order with no loss or duplication.
- expected_len=8, send packets of 8, 7 and 9 words -> len_errors=2, last_pkt_len=9, packets_received=3.
- enable dropped at word 3 of 16 -> all 16 stored, then IDLE; the next packet is fully discarded (discarded_words=16).
- areset asserted mid-packet with 10 words buffered -> next cycle fifo_count=0, all counters 0, tready=1, state IDLE; rd_en gives rd_valid=0.
